// File: rtl/shifter_pkg.sv
// Shared constants and types for the registered barrel shifter.
package shifter_pkg;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef logic [WIDTH-1:0]   data_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational log2(WIDTH)-stage shift/rotate network; optional rotate via SHIFTER_ROTATE_EN.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs every cycle.
module barrel_shift_core #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               direction,
`ifdef SHIFTER_ROTATE_EN
  input  logic               rotate,
`endif
  output logic [WIDTH-1:0]   next
);
  import shifter_pkg::*;

  logic             left;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] net_out;
  logic [WIDTH-1:0] stage [SHAMT_W+1];

  assign left = (direction == DIR_LEFT);

  // Right shifts reuse the left network by reversing the operand on the way in and out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev_in
    assign operand[i] = left ? data[i] : data[WIDTH-1-i];
  end

  assign stage[0] = operand;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int STEP = 1 << s;
    logic [STEP-1:0]  fill;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFTER_ROTATE_EN
    assign fill = rotate ? stage[s][WIDTH-1:WIDTH-STEP] : '0;
`else
    assign fill = '0;
`endif
    assign shifted    = {stage[s][WIDTH-STEP-1:0], fill};
    assign stage[s+1] = amount[s] ? shifted : stage[s];
  end

  assign net_out = stage[SHAMT_W];

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev_out
    assign next[i] = left ? net_out[i] : net_out[WIDTH-1-i];
  end

endmodule

// File: rtl/shifter_circuit_core.sv
// Registered logical barrel shifter (rotate mode when SHIFTER_ROTATE_EN is defined).
// Latency: 1 cycle from in_valid sample to result/out_valid.
// Backpressure: none; accepts one operand per cycle, result holds when idle.
module shifter_circuit_core #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               shift_direction,
`ifdef SHIFTER_ROTATE_EN
  input  logic               rotate_en,
`endif
  output logic [WIDTH-1:0]   result,
  output logic               out_valid
);
  import shifter_pkg::*;

  logic [WIDTH-1:0] next_result;

  barrel_shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data      (data_in),
    .amount    (shift_amount),
    .direction (shift_direction),
`ifdef SHIFTER_ROTATE_EN
    .rotate    (rotate_en),
`endif
    .next      (next_result)
  );

  // Result is only loaded on qualified cycles so it stays X-free after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= next_result;
      end
    end
  end

endmodule

// File: tb/tb_shifter_circuit_core.sv
// Scoreboard bench for shifter_circuit_core; covers rotate mode when SHIFTER_ROTATE_EN is defined.
module tb_shifter_circuit_core;
  import shifter_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid;
  data_t  data_in;
  shamt_t shift_amount;
  logic   shift_direction;
  logic   rotate_en;
  data_t  result;
  logic   out_valid;

  int     n_checks = 0;
  int     n_errors = 0;
  data_t  sb[$];
  data_t  last_res;

  always #5 clk = ~clk;

  shifter_circuit_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .data_in         (data_in),
    .shift_amount    (shift_amount),
    .shift_direction (shift_direction),
`ifdef SHIFTER_ROTATE_EN
    .rotate_en       (rotate_en),
`endif
    .result          (result),
    .out_valid       (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic data_t ref_op(input data_t d, input int amt, input logic dir, input logic rot);
    logic [15:0] wide;
    data_t       r;
    if (dir == DIR_LEFT) begin
      wide = {8'h00, d} << amt;
      r    = wide[7:0] | (rot ? wide[15:8] : 8'h00);
    end else begin
      wide = {d, 8'h00} >> amt;
      r    = wide[15:8] | (rot ? wide[7:0] : 8'h00);
    end
    return r;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic exp_v;
    logic in_rst;
    in_rst = !rst_n;
    exp_v  = in_valid && rst_n;
    #1;
    if (in_rst || !rst_n) begin
      last_res = '0;
      check("rst_result", result, 0);
      check("rst_out_valid", out_valid, 0);
    end else begin
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          last_res = sb.pop_front();
          check("result", result, last_res);
        end
      end else begin
        check("hold_result", result, last_res);
      end
    end
  end

  task automatic send(input data_t d, input shamt_t amt, input logic dir, input logic rot,
                      input data_t exp);
    @(negedge clk);
    in_valid        = 1'b1;
    data_in         = d;
    shift_amount    = amt;
    shift_direction = dir;
    rotate_en       = rot;
    sb.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      data_in  = data_t'($urandom);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    in_valid        = 1'b1;
    data_in         = data_t'($urandom);
    shift_amount    = shamt_t'($urandom);
    shift_direction = 1'($urandom);
    rotate_en       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid        = 1'($urandom);
      data_in         = data_t'($urandom);
      shift_amount    = shamt_t'($urandom);
      shift_direction = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(2);

    // Directed vectors with hand-computed results.
    send(8'h81, 3'd3, DIR_LEFT,  1'b0, 8'h08);
    send(8'h81, 3'd3, DIR_RIGHT, 1'b0, 8'h10);
    send(8'hFF, 3'd7, DIR_RIGHT, 1'b0, 8'h01);
    idle(1);
    send(8'hA5, 3'd0, DIR_LEFT,  1'b0, 8'hA5);
    send(8'hA5, 3'd0, DIR_RIGHT, 1'b0, 8'hA5);
    send(8'hFF, 3'd7, DIR_LEFT,  1'b0, 8'h80);
    send(8'h00, 3'd5, DIR_LEFT,  1'b0, 8'h00);
    send(8'h3C, 3'd7, DIR_LEFT,  1'b0, 8'h00);
    send(8'h96, 3'd2, DIR_RIGHT, 1'b0, 8'h25);
`ifdef SHIFTER_ROTATE_EN
    send(8'h81, 3'd3, DIR_LEFT,  1'b1, 8'h0C);
    send(8'h81, 3'd3, DIR_RIGHT, 1'b1, 8'h30);
    send(8'hA5, 3'd0, DIR_LEFT,  1'b1, 8'hA5);
`endif
    idle(2);

    // Back-to-back random stream, then idle hold.
    for (int k = 0; k < 10; k++) begin
      data_t  d;
      shamt_t a;
      logic   dir;
      logic   rot;
      d   = data_t'($urandom);
      a   = shamt_t'($urandom);
      dir = 1'($urandom);
`ifdef SHIFTER_ROTATE_EN
      rot = 1'($urandom);
`else
      rot = 1'b0;
`endif
      send(d, a, dir, rot, ref_op(d, int'(a), dir, rot));
    end
    idle(3);

    // Make result non-zero, then reset with a capture pending.
    send(8'hF0, 3'd1, DIR_RIGHT, 1'b0, 8'h78);
    @(negedge clk);
    in_valid        = 1'b1;
    data_in         = 8'h55;
    shift_amount    = 3'd1;
    shift_direction = DIR_LEFT;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 0);
    check("async_rst_out_valid", out_valid, 0);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(1);
    send(8'h0F, 3'd4, DIR_LEFT, 1'b0, 8'hF0);
    idle(3);

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
